// File: rtl/eks_scheduler.sv
// Sequencer for the bcrypt EksBlowfish cost loop: pi init, expandKey setup,
// 2^cost key/salt pass pairs, then ENC_ROUNDS x ENC_BLOCKS encipherments.
`timescale 1ns/1ps
module eks_scheduler #(
  parameter int unsigned COST_MIN   = 4,
  parameter int unsigned COST_MAX   = 31,
  parameter int unsigned ENC_ROUNDS = 64,
  parameter int unsigned ENC_BLOCKS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  cost,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        init_start,
  input  logic        init_done,
  output logic        ek_start,
  output logic        ek_load_salt,
  output logic [1:0]  ek_mode,
  input  logic        ek_done,
  output logic        enc_start,
  output logic [1:0]  enc_block,
  input  logic        enc_done,
  output logic [31:0] iter_remain
);

  localparam int unsigned RW = (ENC_ROUNDS > 1) ? $clog2(ENC_ROUNDS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INIT_WAIT, S_SETUP, S_SETUP_WAIT, S_LKEY, S_LKEY_WAIT,
    S_LSALT, S_LSALT_WAIT, S_ENC, S_ENC_WAIT, S_DONE
  } state_t;

  state_t         r_state;
  logic [4:0]     r_cost;
  logic [RW-1:0]  r_round;
  logic [31:0]    r_iter;
  logic           r_busy, r_done, r_error, r_init_start;
  logic           r_ek_start, r_ek_load_salt, r_enc_start;
  logic [1:0]     r_ek_mode, r_enc_block;

  logic [31:0]    w_cost_ext;
  logic           w_cost_ok;
  logic [31:0]    w_iter_dec;
  logic           w_last_blk;
  logic           w_last_round;

  // Widened so the range test does not degenerate to a constant comparison.
  assign w_cost_ext   = {27'd0, cost};
  assign w_cost_ok    = (w_cost_ext >= COST_MIN) && (w_cost_ext <= COST_MAX);
  assign w_iter_dec   = r_iter - 32'd1;
  assign w_last_blk   = (r_enc_block == 2'(ENC_BLOCKS - 1));
  assign w_last_round = (r_round == RW'(ENC_ROUNDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cost         <= '0;
      r_round        <= '0;
      r_iter         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_init_start   <= 1'b0;
      r_ek_start     <= 1'b0;
      r_ek_load_salt <= 1'b0;
      r_ek_mode      <= '0;
      r_enc_start    <= 1'b0;
      r_enc_block    <= '0;
    end else begin
      r_init_start   <= 1'b0;
      r_ek_start     <= 1'b0;
      r_ek_load_salt <= 1'b0;
      r_enc_start    <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cost_ok) begin
              r_cost       <= cost;
              r_busy       <= 1'b1;
              r_init_start <= 1'b1;
              r_state      <= S_INIT;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_INIT: r_state <= S_INIT_WAIT;
        S_INIT_WAIT: begin
          if (init_done) begin
            r_ek_start     <= 1'b1;
            r_ek_load_salt <= 1'b1;
            r_ek_mode      <= 2'd0;
            r_state        <= S_SETUP;
          end
        end
        S_SETUP: r_state <= S_SETUP_WAIT;
        S_SETUP_WAIT: begin
          if (ek_done) begin
            r_iter     <= 32'd1 << r_cost;
            r_ek_start <= 1'b1;
            r_ek_mode  <= 2'd1;
            r_state    <= S_LKEY;
          end
        end
        S_LKEY: r_state <= S_LKEY_WAIT;
        S_LKEY_WAIT: begin
          if (ek_done) begin
            r_ek_start <= 1'b1;
            r_ek_mode  <= 2'd2;
            r_state    <= S_LSALT;
          end
        end
        S_LSALT: r_state <= S_LSALT_WAIT;
        S_LSALT_WAIT: begin
          if (ek_done) begin
            r_iter <= w_iter_dec;
            if (w_iter_dec == 32'd0) begin
              r_enc_start <= 1'b1;
              r_enc_block <= '0;
              r_round     <= '0;
              r_state     <= S_ENC;
            end else begin
              r_ek_start <= 1'b1;
              r_ek_mode  <= 2'd1;
              r_state    <= S_LKEY;
            end
          end
        end
        S_ENC: r_state <= S_ENC_WAIT;
        S_ENC_WAIT: begin
          if (enc_done) begin
            if (w_last_blk) begin
              r_enc_block <= '0;
              if (w_last_round) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_round     <= r_round + RW'(1);
                r_enc_start <= 1'b1;
                r_state     <= S_ENC;
              end
            end else begin
              r_enc_block <= r_enc_block + 2'd1;
              r_enc_start <= 1'b1;
              r_state     <= S_ENC;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign init_start   = r_init_start;
  assign ek_start     = r_ek_start;
  assign ek_load_salt = r_ek_load_salt;
  assign ek_mode      = r_ek_mode;
  assign enc_start    = r_enc_start;
  assign enc_block    = r_enc_block;
  assign iter_remain  = r_iter;

endmodule

// File: tb/tb_eks_scheduler.sv
// Directed bench for eks_scheduler: auto/manual engine responders, pulse
// logging on the falling edge, and hand-computed expectations.
`timescale 1ns/1ps
module tb_eks_scheduler;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  cost;
  logic        busy, done, error, init_start, ek_start, ek_load_salt, enc_start;
  logic [1:0]  ek_mode, enc_block;
  logic [31:0] iter_remain;
  logic        init_done, ek_done, enc_done;

  logic a_init = 1'b0, a_ek = 1'b0, a_enc = 1'b0;
  logic r_init_d = 1'b0, r_ek_d = 1'b0, r_enc_d = 1'b0;
  logic m_init = 1'b0, m_ek = 1'b0, m_enc = 1'b0;
  int   cnt_init = 0, cnt_ek = 0, cnt_enc = 0;

  int n_init, n_ek, n_enc, n_done, n_err, n_salt, n_encdone, encdone_at_done;
  logic [1:0] mode_log [0:127];
  logic       salt_log [0:127];
  logic [1:0] blk_log  [0:255];

  int errors = 0;
  int checks = 0;

  assign init_done = r_init_d | m_init;
  assign ek_done   = r_ek_d   | m_ek;
  assign enc_done  = r_enc_d  | m_enc;

  eks_scheduler #(.COST_MIN(4), .COST_MAX(31), .ENC_ROUNDS(64), .ENC_BLOCKS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .cost(cost),
    .busy(busy), .done(done), .error(error),
    .init_start(init_start), .init_done(init_done),
    .ek_start(ek_start), .ek_load_salt(ek_load_salt), .ek_mode(ek_mode), .ek_done(ek_done),
    .enc_start(enc_start), .enc_block(enc_block), .enc_done(enc_done),
    .iter_remain(iter_remain)
  );

  always #5 clk = ~clk;

  // Log pulses, then drive each auto-responder's done 3 cycles after its start.
  always @(negedge clk) begin
    if (init_start) n_init++;
    if (ek_start) begin
      if (n_ek < 128) begin
        mode_log[n_ek] = ek_mode;
        salt_log[n_ek] = ek_load_salt;
      end
      n_ek++;
    end
    if (ek_load_salt) n_salt++;
    if (enc_start) begin
      if (n_enc < 256) blk_log[n_enc] = enc_block;
      n_enc++;
    end
    if (done) begin
      n_done++;
      encdone_at_done = n_encdone;
    end
    if (error) n_err++;

    r_init_d = 1'b0;
    if (cnt_init > 0) begin cnt_init--; if (cnt_init == 0) r_init_d = 1'b1; end
    if (init_start && a_init) cnt_init = 3;
    r_ek_d = 1'b0;
    if (cnt_ek > 0) begin cnt_ek--; if (cnt_ek == 0) r_ek_d = 1'b1; end
    if (ek_start && a_ek) cnt_ek = 3;
    r_enc_d = 1'b0;
    if (cnt_enc > 0) begin
      cnt_enc--;
      if (cnt_enc == 0) begin r_enc_d = 1'b1; n_encdone++; end
    end
    if (enc_start && a_enc) cnt_enc = 3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    n_init = 0; n_ek = 0; n_enc = 0; n_done = 0; n_err = 0; n_salt = 0;
    n_encdone = 0; encdone_at_done = 0;
  endtask

  task automatic issue_start(input logic [4:0] c);
    start = 1'b1;
    cost  = c;
    tick(1);
    start = 1'b0;
    cost  = 5'd7;
  endtask

  task automatic run_hash(input string tag, input logic [4:0] c);
    int drops, mode_bad, salt_bad, blk_bad, exp_ek;
    logic got;
    drops = 0; mode_bad = 0; salt_bad = 0; blk_bad = 0; got = 1'b0;
    exp_ek = 1 + 2 * (1 << c);
    clear_logs();
    a_init = 1'b1; a_ek = 1'b1; a_enc = 1'b1;
    issue_start(c);
    for (int k = 0; k < 6000; k++) begin
      if (busy !== 1'b1) drops++;
      if (done === 1'b1) begin got = 1'b1; break; end
      start = (k == 60);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    tick(1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_busy_drops"}, drops, 0);
    check({tag, "_n_init"}, n_init, 1);
    check({tag, "_n_ek"}, n_ek, exp_ek);
    check({tag, "_n_enc"}, n_enc, 192);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_n_salt"}, n_salt, 1);
    check({tag, "_encdone_at_done"}, encdone_at_done, 192);
    check({tag, "_iter_end"}, iter_remain, 0);
    for (int i = 0; i < n_ek && i < 128; i++) begin
      if (mode_log[i] !== ((i == 0) ? 2'd0 : ((i % 2) == 1) ? 2'd1 : 2'd2)) mode_bad++;
      if (salt_log[i] !== (i == 0)) salt_bad++;
    end
    for (int i = 0; i < n_enc && i < 256; i++)
      if (blk_log[i] !== 2'(i % 3)) blk_bad++;
    check({tag, "_mode_seq"}, mode_bad, 0);
    check({tag, "_salt_seq"}, salt_bad, 0);
    check({tag, "_blk_seq"}, blk_bad, 0);
  endtask

  initial begin
    int lk, n_ek_snap;
    logic got;
    reset = 1'b1; start = 1'b0; cost = 5'd0;
    clear_logs();
    tick(2);
    check("rst_outs", {busy, done, error, init_start, ek_start, ek_load_salt,
                       ek_mode, enc_start, enc_block}, 0);
    check("rst_iter", iter_remain, 0);
    reset = 1'b0;
    tick(1);

    // Spurious done inputs while idle.
    clear_logs();
    m_init = 1'b1; m_ek = 1'b1; m_enc = 1'b1;
    tick(1);
    m_init = 1'b0; m_ek = 1'b0; m_enc = 1'b0;
    tick(3);
    check("idle_spur_busy", busy, 0);
    check("idle_spur_starts", n_init + n_ek + n_enc, 0);

    // Illegal costs.
    a_init = 1'b1; a_ek = 1'b1; a_enc = 1'b1;
    issue_start(5'd3);
    check("err_c3_pulse", error, 1);
    check("err_c3_busy", busy, 0);
    tick(1);
    check("err_c3_width", error, 0);
    issue_start(5'd0);
    check("err_c0_pulse", error, 1);
    tick(5);
    check("err_count", n_err, 2);
    check("err_busy", busy, 0);
    check("err_no_starts", n_init + n_ek + n_enc, 0);

    run_hash("c4", 5'd4);

    // cost=31: manual expandKey handshakes, spurious done in issue/wrong-wait cycles.
    clear_logs();
    a_init = 1'b1; a_ek = 1'b0; a_enc = 1'b0;
    issue_start(5'd31);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (ek_start === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("c31_setup_seen", got, 1);
    m_ek = 1'b1; m_enc = 1'b1;
    tick(1);
    m_ek = 1'b0; m_enc = 1'b0;
    tick(3);
    check("c31_issue_done_ignored", n_ek, 1);
    check("c31_iter_pre", iter_remain, 0);
    m_ek = 1'b1;
    tick(1);
    m_ek = 1'b0;
    check("c31_iter_load", iter_remain, 32'h8000_0000);
    check("c31_lkey_start", {ek_start, ek_mode}, {1'b1, 2'd1});
    m_ek = 1'b1;
    tick(1);
    m_ek = 1'b0;
    tick(2);
    check("c31_lkey_issue_ignored", n_ek, 2);
    m_enc = 1'b1;
    tick(1);
    m_enc = 1'b0;
    tick(1);
    check("c31_wrong_done_ignored", n_ek, 2);
    m_ek = 1'b1;
    tick(1);
    m_ek = 1'b0;
    check("c31_lsalt_start", {ek_start, ek_load_salt, ek_mode}, {1'b1, 1'b0, 2'd2});
    tick(1);
    m_ek = 1'b1;
    tick(1);
    m_ek = 1'b0;
    check("c31_iter_dec", iter_remain, 32'h7FFF_FFFF);
    check("c31_next_lkey", ek_mode, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("c31_abort_busy", busy, 0);

    // Reset inside LKEY_WAIT of the 5th key pass.
    clear_logs();
    a_init = 1'b1; a_ek = 1'b1; a_enc = 1'b1;
    issue_start(5'd4);
    lk = 0; got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (ek_start === 1'b1 && ek_mode === 2'd1) lk++;
      if (lk == 5) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("rst5_reached", got, 1);
    tick(1);
    check("rst5_iter_before", iter_remain, 12);
    check("rst5_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("rst5_async_outs", {busy, done, error, init_start, ek_start, ek_load_salt,
                              ek_mode, enc_start, enc_block}, 0);
    check("rst5_async_iter", iter_remain, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    n_ek_snap = n_ek;
    tick(5);
    check("rst5_late_done_busy", busy, 0);
    check("rst5_late_done_starts", n_ek, n_ek_snap);

    run_hash("rerun", 5'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
